// File: rtl/geofence_pkg.sv
// Shared types and sizing for the N-gon geofence checker.
// Holds default parameters, the cross-product width helper, point and FSM types.
package geofence_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int N_VERT_DEF  = 6;
  localparam int CW_MAX      = 16;

  function automatic int xprod_w(input int cw);
    return 2 * cw + 3;
  endfunction

  // Coordinates held zero-extended to the widest legal width.
  typedef struct packed {
    logic [CW_MAX-1:0] x;
    logic [CW_MAX-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    READ,
    SORT,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/geofence_cross.sv
// Combinational cross product (B-A)x(C-A) on COORD_W-bit unsigned points.
// Ports: a_i, b_i, c_i points in; cross_o signed 2*COORD_W+3 bit result.
module geofence_cross
  import geofence_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  localparam int XW     = xprod_w(COORD_W)
) (
  input  point_t               a_i,
  input  point_t               b_i,
  input  point_t               c_i,
  output logic signed [XW-1:0] cross_o
);

  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;

  logic signed [DW-1:0] bax, bay, cax, cay;
  logic signed [PW-1:0] p1, p2;

  // Upper bits of the stored points are always zero.
  logic [3*$bits(point_t)-1:0] unused_pts;
  assign unused_pts = {a_i, b_i, c_i};

  assign bax = $signed({1'b0, b_i.x[COORD_W-1:0]})
             - $signed({1'b0, a_i.x[COORD_W-1:0]});
  assign bay = $signed({1'b0, b_i.y[COORD_W-1:0]})
             - $signed({1'b0, a_i.y[COORD_W-1:0]});
  assign cax = $signed({1'b0, c_i.x[COORD_W-1:0]})
             - $signed({1'b0, a_i.x[COORD_W-1:0]});
  assign cay = $signed({1'b0, c_i.y[COORD_W-1:0]})
             - $signed({1'b0, a_i.y[COORD_W-1:0]});

  assign p1 = PW'(bax) * PW'(cay);
  assign p2 = PW'(bay) * PW'(cax);

  assign cross_o = $signed({p1[PW-1], p1})
                 - $signed({p2[PW-1], p2});

endmodule

// File: rtl/geofence_ngon.sv
// Convex N-gon geofence: takes T then N_VERT vertices, sorts them CCW about
// P0 with one shared cross unit, then reports T strictly inside.
// Ports: clk, reset (sync, active-low), in_valid/in_ready/X/Y point stream,
// valid result strobe, is_inside result, on_edge when GEOFENCE_ONEDGE_EN.
module geofence_ngon
  import geofence_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int N_VERT  = N_VERT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  output logic               valid,
  output logic               is_inside
`ifdef GEOFENCE_ONEDGE_EN
  ,
  output logic               on_edge
`endif
);

  localparam int XW    = xprod_w(COORD_W);
  localparam int CNT_W = $clog2(N_VERT + 1);
  localparam int IW    = $clog2(N_VERT);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IW-1:0]        pass_q, j_q, k_q;
  logic [IW-1:0]        j1, k1, widx;
  point_t               tgt_q;
  point_t               pts_q [N_VERT];
  point_t               pin, ca, cb, cc;
  logic                 acc_q, acc_d;
  logic signed [XW-1:0] xres;
  logic                 neg, zero, pos, hs;
`ifdef GEOFENCE_ONEDGE_EN
  logic                 nn_q, nn_d, z_q, z_d;
`endif

  assign hs   = in_valid && in_ready;
  assign pin  = '{x: CW_MAX'(X), y: CW_MAX'(Y)};
  assign widx = IW'(cnt_q - 1'b1);
  assign j1   = j_q + 1'b1;
  assign k1   = (k_q == IW'(N_VERT - 1)) ? '0 : k_q + 1'b1;

  // SORT compares neighbours about P0; CHECK walks edges against T.
  always_comb begin
    ca = pts_q[0];
    cb = pts_q[j_q];
    cc = pts_q[j1];
    if (state_q == CHECK) begin
      ca = pts_q[k_q];
      cb = pts_q[k1];
      cc = tgt_q;
    end
  end

  geofence_cross #(
    .COORD_W(COORD_W)
  ) u_cross (
    .a_i    (ca),
    .b_i    (cb),
    .c_i    (cc),
    .cross_o(xres)
  );

  assign neg   = xres[XW-1];
  assign zero  = (xres == '0);
  assign pos   = !neg && !zero;
  assign acc_d = acc_q && pos;
`ifdef GEOFENCE_ONEDGE_EN
  assign nn_d  = nn_q && !neg;
  assign z_d   = z_q || zero;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= READ;
      in_ready  <= 1'b1;
      valid     <= 1'b0;
      is_inside <= 1'b0;
      cnt_q     <= '0;
      pass_q    <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= 1'b0;
      tgt_q     <= '0;
      for (int i = 0; i < N_VERT; i++) begin
        pts_q[i] <= '0;
      end
`ifdef GEOFENCE_ONEDGE_EN
      nn_q      <= 1'b0;
      z_q       <= 1'b0;
      on_edge   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        READ: begin
          if (hs) begin
            if (cnt_q == '0) tgt_q <= pin;
            else pts_q[widx] <= pin;
            if (cnt_q == CNT_W'(N_VERT)) begin
              state_q  <= SORT;
              in_ready <= 1'b0;
              cnt_q    <= '0;
              pass_q   <= '0;
              j_q      <= IW'(1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SORT: begin
          // Collinear (zero) leaves the pair as is.
          if (neg) begin
            pts_q[j_q] <= cc;
            pts_q[j1]  <= cb;
          end
          if (j_q == IW'(N_VERT - 2)) begin
            j_q <= IW'(1);
            if (pass_q == IW'(N_VERT - 3)) begin
              state_q <= CHECK;
              k_q     <= '0;
              acc_q   <= 1'b1;
`ifdef GEOFENCE_ONEDGE_EN
              nn_q    <= 1'b1;
              z_q     <= 1'b0;
`endif
            end else begin
              pass_q <= pass_q + 1'b1;
            end
          end else begin
            j_q <= j1;
          end
        end
        CHECK: begin
          acc_q <= acc_d;
          k_q   <= k1;
`ifdef GEOFENCE_ONEDGE_EN
          nn_q  <= nn_d;
          z_q   <= z_d;
`endif
          if (k_q == IW'(N_VERT - 1)) begin
            state_q   <= DONE;
            valid     <= 1'b1;
            is_inside <= acc_d;
`ifdef GEOFENCE_ONEDGE_EN
            on_edge   <= nn_d && z_d;
`endif
          end
        end
        DONE: begin
          state_q  <= READ;
          valid    <= 1'b0;
          in_ready <= 1'b1;
        end
        default: state_q <= READ;
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_ngon.sv
// Directed bench for geofence_ngon: a hexagon instance and a triangle
// instance share clock, reset and point bus; sel picks the target.
module tb_geofence_ngon;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       sel;
  logic [9:0] X, Y;
  logic       iv6, iv3, rdy6, rdy3, vld6, vld3, ins6, ins3;
  logic       rdy, vld, ins;
`ifdef GEOFENCE_ONEDGE_EN
  logic       edg6, edg3, edg;
`endif

  int checks = 0;
  int errors = 0;
  int px [9];
  int py [9];
  int hx [6] = '{200, 300, 150, 350, 200, 300};
  int hy [6] = '{100, 300, 200, 200, 300, 100};

  always #5 clk = ~clk;

  assign iv6 = in_valid & ~sel;
  assign iv3 = in_valid & sel;
  assign rdy = sel ? rdy3 : rdy6;
  assign vld = sel ? vld3 : vld6;
  assign ins = sel ? ins3 : ins6;
`ifdef GEOFENCE_ONEDGE_EN
  assign edg = sel ? edg3 : edg6;
`endif

  geofence_ngon #(.COORD_W(10), .N_VERT(6)) u_hex (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv6),
    .in_ready (rdy6),
    .X        (X),
    .Y        (Y),
    .valid    (vld6),
    .is_inside(ins6)
`ifdef GEOFENCE_ONEDGE_EN
    ,
    .on_edge  (edg6)
`endif
  );

  geofence_ngon #(.COORD_W(10), .N_VERT(3)) u_tri (
    .clk      (clk),
    .reset    (reset),
    .in_valid (iv3),
    .in_ready (rdy3),
    .X        (X),
    .Y        (Y),
    .valid    (vld3),
    .is_inside(ins3)
`ifdef GEOFENCE_ONEDGE_EN
    ,
    .on_edge  (edg3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic set_hex(input int tx, input int ty, input bit rev);
    px[0] = tx;
    py[0] = ty;
    for (int i = 0; i < 6; i++) begin
      px[i+1] = rev ? hx[5-i] : hx[i];
      py[i+1] = rev ? hy[5-i] : hy[i];
    end
  endtask

  task automatic set_pt(input int i, input int x, input int y);
    px[i] = x;
    py[i] = y;
  endtask

  task automatic run_set(input string tag, input bit s, input int n,
                         input bit exp_in, input bit exp_edge,
                         input bit hold);
    int g, lat, lowc, explat;
    explat = (n - 2) * (n - 2) + n;
    sel = s;
    for (int i = 0; i <= n; i++) begin
      X = 10'(px[i]);
      Y = 10'(py[i]);
      in_valid = 1'b1;
      g = 0;
      while (!rdy && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) chk({tag, "_rdy_timeout"}, g, 0);
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
    lat = 0;
    lowc = 0;
    while (!vld && lat < 200) begin
      if (!rdy) lowc++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, explat);
    chk({tag, "_busy"}, lowc, explat);
    chk({tag, "_inside"}, ins, exp_in);
    chk({tag, "_rdy_done"}, rdy, 0);
`ifdef GEOFENCE_ONEDGE_EN
    chk({tag, "_edge"}, edg, exp_edge);
`else
    if (exp_edge) g = 0;
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, vld, 0);
    chk({tag, "_rdy_back"}, rdy, 1);
    chk({tag, "_hold"}, ins, exp_in);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int seen;
    reset = 1'b0;
    in_valid = 1'b0;
    sel = 1'b0;
    X = '0;
    Y = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy6", rdy6, 1);
    chk("rst_vld6", vld6, 0);
    chk("rst_ins6", ins6, 0);
    chk("rst_rdy3", rdy3, 1);
    reset = 1'b1;
    @(negedge clk);

    set_hex(250, 200, 1'b0);
    run_set("hex_in", 1'b0, 6, 1'b1, 1'b0, 1'b0);
    set_hex(400, 400, 1'b0);
    run_set("hex_out", 1'b0, 6, 1'b0, 1'b0, 1'b0);
    set_hex(250, 100, 1'b0);
    run_set("hex_edge", 1'b0, 6, 1'b0, 1'b1, 1'b0);

    set_pt(0, 1, 1);
    set_pt(1, 0, 0);
    set_pt(2, 1023, 0);
    set_pt(3, 0, 1023);
    run_set("tri_in", 1'b1, 3, 1'b1, 1'b0, 1'b0);
    set_pt(0, 1023, 1023);
    set_pt(2, 0, 1023);
    set_pt(3, 1023, 0);
    run_set("tri_out", 1'b1, 3, 1'b0, 1'b0, 1'b0);

    sel = 1'b0;
    set_hex(400, 400, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      X = 10'(px[i]);
      Y = 10'(py[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_rdy", rdy6, 1);
    chk("midrst_vld", vld6, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (vld6) seen++;
    end
    chk("midrst_novalid", seen, 0);
    set_hex(250, 200, 1'b1);
    run_set("after_rst", 1'b0, 6, 1'b1, 1'b0, 1'b0);

    set_hex(250, 200, 1'b1);
    run_set("b2b_in", 1'b0, 6, 1'b1, 1'b0, 1'b1);
    set_hex(150, 200, 1'b0);
    run_set("b2b_vtx", 1'b0, 6, 1'b0, 1'b1, 1'b1);
    set_hex(400, 400, 1'b1);
    run_set("b2b_out", 1'b0, 6, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
